// File: rtl/sigma_ch_scheduler.sv
// Round-robin scheduler sharing one sign-magnitude accumulator between NCH channels.
// Optional window stall timeout enabled by defining SIGMA_TIMEOUT_EN.
module sigma_ch_scheduler #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned NPTS    = 16,
  parameter int unsigned DW      = 8,
  parameter int unsigned SW      = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NCH-1:0]          req_valid,
  input  logic [NCH*DW-1:0]       req_data,
  output logic [NCH-1:0]          req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SW-1:0]           out_data,
  output logic [$clog2(NCH)-1:0]  out_ch,
  output logic                    busy,
  output logic                    abort
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned NW = $clog2(NPTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   ptr_q, ptr_d;
  logic [SW-1:0]   sigma_q, sigma_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]  req_ready_q, req_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [SW-1:0]   out_data_q, out_data_d;
  logic [CW-1:0]   out_ch_q, out_ch_d;
  logic            busy_q, busy_d;
  logic            abort_q, abort_d;

`ifdef SIGMA_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]   stall_q, stall_d;
`else
  logic            unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  logic [DW-1:0]   req_word [NCH];
  logic [DW-1:0]   sample_c;
  logic [SW-1:0]   mag_c;
  logic [SW-1:0]   x_c;
  logic            accept_c;
  logic            last_c;

  // First valid channel after the pointer, wrapping modulo NCH
  function automatic logic [CW-1:0] rr_pick(input logic [NCH-1:0] v, input logic [CW-1:0] p);
    logic [CW-1:0] pick;
    logic          found;
    int unsigned   idx;
    pick  = p;
    found = 1'b0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = (32'(p) + i) % NCH;
      if (!found && v[CW'(idx)]) begin
        pick  = CW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      req_word[i] = req_data[i*DW +: DW];
    end
  end

  // Sign-magnitude to two's complement; 0x80 style negative zero maps to 0
  always_comb begin
    sample_c = req_word[grant_q];
    mag_c    = SW'(sample_c[DW-2:0]);
    x_c      = sample_c[DW-1] ? (SW'(0) - mag_c) : mag_c;
    accept_c = (state_q == ACCUM) && req_valid[grant_q] && req_ready_q[grant_q];
    last_c   = (cnt_q == NW'(NPTS - 1));
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    sigma_d     = sigma_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    abort_d     = 1'b0;
`ifdef SIGMA_TIMEOUT_EN
    stall_d     = stall_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          grant_d = rr_pick(req_valid, ptr_q);
          sigma_d = '0;
          cnt_d   = '0;
`ifdef SIGMA_TIMEOUT_EN
          stall_d = '0;
`endif
          state_d = ACCUM;
        end
      end

      ACCUM: begin
        if (accept_c) begin
`ifdef SIGMA_TIMEOUT_EN
          stall_d = '0;
`endif
          if (last_c) begin
            out_data_d  = sigma_q + x_c;
            out_ch_d    = grant_q;
            out_valid_d = 1'b1;
            ptr_d       = grant_q;
            state_d     = OUT;
          end else begin
            sigma_d = sigma_q + x_c;
            cnt_d   = cnt_q + NW'(1);
          end
        end
`ifdef SIGMA_TIMEOUT_EN
        else if (stall_q == TW'(TIMEOUT - 1)) begin
          // Stalled window: drop partial sum, move the pointer past this channel
          stall_d = '0;
          sigma_d = '0;
          cnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = grant_q;
          state_d = IDLE;
        end else begin
          stall_d = stall_q + TW'(1);
        end
`endif
      end

      OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    // Ready decoded from next state so it is a pure flop output
    req_ready_d = (state_d == ACCUM) ? (NCH'(1) << grant_d) : '0;
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= CW'(NCH - 1);
      sigma_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
`ifdef SIGMA_TIMEOUT_EN
      stall_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      sigma_q     <= sigma_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      busy_q      <= busy_d;
      abort_q     <= abort_d;
`ifdef SIGMA_TIMEOUT_EN
      stall_q     <= stall_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign busy      = busy_q;
  assign abort     = abort_q;

endmodule
